// File: rtl/smul_arbiter_pkg.sv
// Shared types and constants for the two-requester sign-magnitude multiplier arbiter.
package smul_arbiter_pkg;

    // Number of requesters sharing the multiplier.
    localparam int NUM_REQ = 2;

    // Operation sequencing: wait for a request, compute, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/smul_core.sv
// Combinational sign-magnitude multiply; the magnitude wraps to DATAWIDTH-1 bits.
module smul_core #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] prod
);

    logic                 sign;
    logic [DATAWIDTH-2:0] mag;

    // Product width equals operand width, so overflow drops the upper bits and
    // a negative zero (sign set, magnitude zero) is passed through untouched.
    always_comb begin
        sign = a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
        mag  = a[DATAWIDTH-2:0] * b[DATAWIDTH-2:0];
        prod = {sign, mag};
    end

endmodule

// File: rtl/smul_arbiter.sv
// Round-robin arbiter granting two requesters access to one sign-magnitude multiplier.
module smul_arbiter
    import smul_arbiter_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [DATAWIDTH-1:0] a0,
    input  logic [DATAWIDTH-1:0] b0,
    input  logic [DATAWIDTH-1:0] a1,
    input  logic [DATAWIDTH-1:0] b1,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [DATAWIDTH-1:0] prod,
    output logic                 busy,
    output logic                 grant_id
);

    state_t               state;
    state_t               state_nx;
    logic                 last_grant;
    logic                 winner;
    logic                 accept;
    logic [DATAWIDTH-1:0] a_p0;
    logic [DATAWIDTH-1:0] b_p0;
    logic [DATAWIDTH-1:0] core_prod;

    smul_core #(
        .DATAWIDTH(DATAWIDTH)
    ) u_core (
        .a    (a_p0),
        .b    (b_p0),
        .prod (core_prod)
    );

    // Winner selection: under contention the requester not granted last wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = req_valid[1];
        end
    end

    // Next-state and handshake outputs; a request is only taken out of reset in IDLE.
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                if (Rst && (req_valid != '0)) begin
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_nx          = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant bookkeeping and the registered product; reset clears any in-flight result.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            prod       <= '0;
        end else begin
            if (accept) begin
                last_grant <= winner;
                grant_id   <= winner;
            end
            if (state == EXEC) begin
                prod <= core_prod;
            end
        end
    end

    // Operand capture on accept, so later input changes cannot disturb the operation.
    always_ff @(posedge Clk) begin
        if (accept) begin
            a_p0 <= winner ? a1 : a0;
            b_p0 <= winner ? b1 : b0;
        end
    end

endmodule

// File: tb/tb_smul_arbiter.sv
// Scoreboard bench for smul_arbiter: a request-level model predicts grants and products,
// a separate monitor compares every presented response against the queued expectation.
module tb_smul_arbiter;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   resp_ready = 2'b00;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   req_ready;
    logic [1:0]   resp_valid;
    logic [W-1:0] prod;
    logic         busy;
    logic         grant_id;

    smul_arbiter #(.DATAWIDTH(W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .prod       (prod),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic [7:0] prod;
        int         due;
    } exp_t;

    exp_t sb[$];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference product from plain integer arithmetic on sign and magnitude.
    function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
        int ma, mb, m, s;
        ma = int'(a) % 128;
        mb = int'(b) % 128;
        m  = (ma * mb) % 128;
        s  = ((int'(a) / 128) + (int'(b) / 128)) % 2;
        return 8'(s * 128 + m);
    endfunction

    // Request-level model: decides accepts and handshakes from the rules, queues expectations.
    bit m_pend = 1'b0;
    int m_age  = 0;
    int m_id   = 0;
    int m_last = 1;

    initial begin : model
        int   exp_rdy;
        int   win;
        exp_t e;
        forever begin
            @(negedge Clk);
            exp_rdy = 0;
            if (!Rst) begin
                chk("req_ready_in_reset", int'(req_ready), 0);
                sb.delete();
                m_pend = 1'b0;
                m_last = 1;
            end else begin
                chk("busy", int'(busy), int'(m_pend));
                if (m_pend) begin
                    chk("grant_id", int'(grant_id), m_id);
                    m_age++;
                    if (m_age >= 2 && resp_ready[m_id]) m_pend = 1'b0;
                end else if (req_valid != 2'b00) begin
                    if (req_valid == 2'b11) win = 1 - m_last;
                    else if (req_valid[1]) win = 1;
                    else win = 0;
                    exp_rdy = (win == 1) ? 2 : 1;
                    e.id   = win;
                    e.prod = (win == 1) ? ref_mul(a1, b1) : ref_mul(a0, b0);
                    e.due  = cyc + 2;
                    sb.push_back(e);
                    m_pend = 1'b1;
                    m_age  = 0;
                    m_id   = win;
                    m_last = win;
                end
                chk("req_ready", int'(req_ready), exp_rdy);
            end
        end
    end

    // Response monitor: compares presented responses against the queue head.
    initial begin : monitor
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge Clk);
            #1;
            if (!Rst) begin
                seen = 1'b0;
            end else if (resp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", int'(resp_valid), 0);
                end else begin
                    chk("resp_valid", int'(resp_valid), (sb[0].id == 1) ? 2 : 1);
                    chk("prod", int'(prod), int'(sb[0].prod));
                    if (!seen) begin
                        chk("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    if (resp_ready[sb[0].id]) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                chk("resp_missing", 0, 1);
                void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic drive(input bit rst, input logic [1:0] rv, input logic [1:0] rr);
        @(posedge Clk);
        #1;
        Rst        = rst;
        req_valid  = rv;
        resp_ready = rr;
    endtask

    task automatic set_ops(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1);
        a0 = x0;
        b0 = y0;
        a1 = x1;
        b1 = y1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b1, 2'b00, 2'b11);
            set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset with requests pending: nothing may be accepted.
        drive(1'b0, 2'b11, 2'b11);
        drive(1'b0, 2'b11, 2'b11);
        drive(1'b1, 2'b00, 2'b11);
        @(negedge Clk);
        chk("rst_prod", int'(prod), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), 0);

        // Mixed sign on requester 0, operands scrambled right after accept.
        drive(1'b1, 2'b01, 2'b11);
        set_ops(8'h83, 8'h05, 8'h00, 8'h00);
        idle(4);

        // Magnitude overflow and negative zero on requester 1.
        drive(1'b1, 2'b10, 2'b11);
        set_ops(8'h00, 8'h00, 8'h10, 8'h10);
        idle(4);
        drive(1'b1, 2'b10, 2'b11);
        set_ops(8'h00, 8'h00, 8'h90, 8'h10);
        idle(4);

        // Held contention straight out of reset: 0, then 1, then 0 again.
        drive(1'b0, 2'b00, 2'b11);
        drive(1'b1, 2'b11, 2'b11);
        set_ops(8'h07, 8'h06, 8'h02, 8'h03);
        repeat (8) drive(1'b1, 2'b11, 2'b11);
        idle(4);

        // Backpressure: three stalled RESP cycles, other ready bit toggling, new request waiting.
        drive(1'b1, 2'b01, 2'b00);
        set_ops(8'hC5, 8'h0B, 8'h00, 8'h00);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b10);
        drive(1'b1, 2'b10, 2'b10);
        set_ops(8'h00, 8'h00, 8'h85, 8'h86);
        drive(1'b1, 2'b10, 2'b00);
        drive(1'b1, 2'b10, 2'b01);
        drive(1'b1, 2'b10, 2'b11);
        idle(4);

        // Reset while a response is pending: it is dropped and requester 0 wins next.
        drive(1'b1, 2'b10, 2'b00);
        set_ops(8'h11, 8'h22, 8'h33, 8'h44);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b11, 2'b11);
        @(negedge Clk);
        chk("rstresp_resp_valid", int'(resp_valid), 0);
        chk("rstresp_prod", int'(prod), 0);
        chk("rstresp_busy", int'(busy), 0);
        idle(4);

        // Random traffic with random backpressure and occasional reset.
        repeat (400) begin
            drive(($urandom_range(0, 63) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)));
            set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(6);
        @(negedge Clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
